// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the 8x8 array multiplier sequencer.
package mul_seq_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int CNT_W = 4;

  localparam int unsigned DISP_MAX_DEF = 9999;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

  // The array always sees magnitudes, so its raw product is |result|.
  function automatic logic exceeds_disp(input logic [RES_W-1:0] mag,
                                        input int unsigned       lim);
    return 32'(mag) > lim;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Two's-complement front/back end for the unsigned array multiplier.
// Used only when SIGNED_MUL_EN is defined.
module mul_sign_fix
  import mul_seq_pkg::*;
(
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  input  logic [RES_W-1:0] prod,
  input  logic             neg,
  output logic [OP_W-1:0]  mag_a,
  output logic [OP_W-1:0]  mag_b,
  output logic             sign_x,
  output logic [RES_W-1:0] prod_fixed
);

  // -128 negates to itself, which reads as 8'h80 = 128 unsigned.
  assign mag_a      = op_a[OP_W-1] ? (~op_a + OP_W'(1)) : op_a;
  assign mag_b      = op_b[OP_W-1] ? (~op_b + OP_W'(1)) : op_b;
  assign sign_x     = op_a[OP_W-1] ^ op_b[OP_W-1];
  assign prod_fixed = neg ? (~prod + RES_W'(1)) : prod;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the combinational 8x8 array multiplier: accept, settle, capture.
// Build option: SIGNED_MUL_EN selects two's-complement operands and result.
//
// state  | meaning
// IDLE   | ready for an operand pair
// SETTLE | operands on the array, counting down settle cycles
// DONE   | result held until the consumer takes it
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter int unsigned DISP_MAX      = DISP_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [RES_W-1:0]  mul_p,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  result,
  output logic              ovf,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    mul_a_q, mul_a_d;
  logic [OP_W-1:0]    mul_b_q, mul_b_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               req_ready_q, req_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;

  logic [OP_W-1:0]    mag_a;
  logic [OP_W-1:0]    mag_b;
  logic [RES_W-1:0]   prod_fixed;
  logic               accept;
  logic               zero_op;

`ifdef SIGNED_MUL_EN
  logic neg_q, neg_d;
  logic sign_x;

  mul_sign_fix u_sign_fix (
    .op_a       (op_a),
    .op_b       (op_b),
    .prod       (mul_p),
    .neg        (neg_q),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .sign_x     (sign_x),
    .prod_fixed (prod_fixed)
  );

  always_comb begin
    neg_d = neg_q;
    if (accept) neg_d = sign_x;
  end

  always_ff @(posedge clk) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end
`else
  assign mag_a      = op_a;
  assign mag_b      = op_b;
  assign prod_fixed = mul_p;
`endif

  assign accept  = (state_q == IDLE) && req_valid && req_ready_q;
  assign zero_op = (op_a == '0) || (op_b == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    req_ready_d = req_ready_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mul_a_d     = mag_a;
          mul_b_d     = mag_b;
          cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          // A zero operand makes the product known without waiting on the array.
          if (zero_op) begin
            result_d    = '0;
            ovf_d       = 1'b0;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = SETTLE;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          result_d    = prod_fixed;
          ovf_d       = exceeds_disp(mul_p, DISP_MAX);
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        // Ready comes back one cycle after the handshake, never in the same cycle.
        if (res_ready) begin
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl; models the array as a plain multiply.
module tb_mul_seq_ctrl;

  localparam int SC = 2;
  localparam int DMAX = 9999;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_res;
  logic        last_ovf;

  mul_seq_ctrl #(.SETTLE_CYCLES(SC), .DISP_MAX(DMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Combinational array stand-in.
  assign mul_p = 16'(mul_a) * 16'(mul_b);

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the arithmetic meaning of the operation, not the FSM.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r, output logic v,
                       output logic [7:0] ma, output logic [7:0] mb,
                       output int lat);
    int sa, sb, p, mag;
`ifdef SIGNED_MUL_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    p   = sa * sb;
    mag = (p < 0) ? -p : p;
    r   = 16'(p);
    v   = mag > DMAX;
    ma  = 8'((sa < 0) ? -sa : sa);
    mb  = 8'((sb < 0) ? -sb : sb);
    lat = (a == 8'd0 || b == 8'd0) ? 1 : SC + 1;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [15:0] er;
    logic        ev;
    logic [7:0]  ema, emb;
    int          elat, n, lat;
    model(a, b, er, ev, ema, emb, elat);
    op_a = a;
    op_b = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("accept_wait", 32'(n < 20), 1);
    step();
    req_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    chk("ready_low_after_accept", req_ready, 0);
    chk("busy_after_accept", busy, 1);
    chk("mul_a", mul_a, ema);
    chk("mul_b", mul_b, emb);
    lat = 1;
    while (!res_valid && lat < 40) begin
      chk("ready_low_settle", req_ready, 0);
      step();
      lat++;
    end
    chk("latency", lat, elat);
    chk("result", result, er);
    chk("ovf", ovf, ev);
    chk("ready_low_done", req_ready, 0);
    last_res = result;
    last_ovf = ovf;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", res_valid, 1);
      chk("hold_result", result, er);
      chk("hold_ovf", ovf, ev);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("valid_drop", res_valid, 0);
    chk("ready_back", req_ready, 1);
    chk("busy_clear", busy, 0);
    chk("mul_a_held", mul_a, ema);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b0;
    op_a = 8'd0;
    op_b = 8'd0;
    step();
    step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    rst = 1'b0;
    step();

    do_op(8'd12, 8'd34, 0);
    chk("t12x34_const", last_res, 408);
    chk("t12x34_ovf_const", last_ovf, 0);

`ifndef SIGNED_MUL_EN
    do_op(8'd255, 8'd255, 5);
    chk("t255_const", last_res, 65025);
    chk("t255_ovf_const", last_ovf, 1);
`endif

    do_op(8'd0, 8'd200, 0);
    chk("tzero_const", last_res, 0);

    // Reset while the array is settling.
    op_a = 8'd100;
    op_b = 8'd100;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_busy", busy, 1);
    chk("mid_no_valid", res_valid, 0);
    rst = 1'b1;
    step();
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_result", result, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_mul_a", mul_a, 0);
    chk("mrst_mul_b", mul_b, 0);
    rst = 1'b0;
    step();
    do_op(8'd3, 8'd3, 0);
    chk("t3x3_const", last_res, 9);

    // Back-to-back with req_valid held high.
    op_a = 8'd6;
    op_b = 8'd7;
    req_valid = 1'b1;
    step();
    op_a = 8'd9;
    op_b = 8'd11;
    begin
      int n;
      n = 0;
      while (!res_valid && n < 40) begin
        chk("b2b_hold_mul_a", mul_a, 6);
        step();
        n++;
      end
      chk("b2b_first_done", res_valid, 1);
      chk("b2b_first_result", result, 42);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("b2b_no_reaccept_mul_a", mul_a, 6);
      chk("b2b_no_reaccept_mul_b", mul_b, 7);
      chk("b2b_ready_back", req_ready, 1);
      step();
      req_valid = 1'b0;
      chk("b2b_second_mul_a", mul_a, 9);
      chk("b2b_second_mul_b", mul_b, 11);
      chk("b2b_second_busy", busy, 1);
      n = 0;
      while (!res_valid && n < 40) begin
        step();
        n++;
      end
      chk("b2b_second_result", result, 99);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end

`ifdef SIGNED_MUL_EN
    do_op(8'hFB, 8'd7, 1);
    chk("sneg_const", last_res, 16'hFFDD);
    do_op(8'h80, 8'h80, 2);
    chk("s128_const", last_res, 16384);
    chk("s128_ovf_const", last_ovf, 1);
    do_op(8'hFF, 8'hFF, 5);
    chk("sm1_const", last_res, 1);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ra = 8'd0;
      if ($urandom_range(0, 7) == 0) rb = 8'd0;
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencing controller for the calculator's 8x8 combinational array multiplier.
- Accepts one operand pair per valid/ready handshake and registers it onto the array inputs.
- Waits a programmable number of settle cycles for the ripple array, then captures the 16-bit product into a result register and presents it with a valid/ready handshake.
- Sits between the keypad/operation decoder and the 7-segment display formatter; also flags results that exceed the display range.

Parameters:
- SETTLE_CYCLES, 2: cycles the array is given to settle after operands are registered; legal range 1..15; 4-bit counter.
- DISP_MAX, 9999: largest magnitude the display shows; ovf asserts above this.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  operand pair valid
- req_ready  out  1  controller can accept operands
- op_a  in  8  multiplicand
- op_b  in  8  multiplier
- mul_a  out  8  registered operand A to the array
- mul_b  out  8  registered operand B to the array
- mul_p  in  16  product from the array
- res_valid  out  1  result available
- res_ready  in  1  consumer takes the result
- result  out  16  registered product
- ovf  out  1  |result| > DISP_MAX; valid while res_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; req_ready=1; res_valid=0; result=0; ovf=0; busy=0; mul_a=0; mul_b=0; settle counter=0.
- FSM has three states: IDLE, SETTLE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at edge T: register op_a/op_b onto mul_a/mul_b and load cnt=SETTLE_CYCLES-1.
  - Zero shortcut: if op_a==0 or op_b==0, skip SETTLE. Load result=0, ovf=0, go to DONE. res_valid is high after edge T.
  - Otherwise go to SETTLE.
- SETTLE:
  - req_ready=0; cnt decrements each cycle.
  - When cnt==0: capture mul_p into result, compute ovf, go to DONE.
  - res_valid rises after edge T+SETTLE_CYCLES, so latency is SETTLE_CYCLES+1 cycles counted from the accept cycle.
- DONE:
  - res_valid=1; result and ovf are held stable.
  - On res_ready: go to IDLE. req_ready returns high the following cycle, so there is no same-cycle re-accept and throughput is one op per SETTLE_CYCLES+2 cycles.
  - res_valid must not drop without res_ready.
- mul_a/mul_b hold their value from accept until the next accept; they are not cleared on completion.
- req_valid while not ready: ignored; op_a/op_b are not sampled.
- rst mid-operation (any state): immediate return to reset values next edge; any in-flight result is discarded.
- Width rules: unsigned 8x8 gives a 16-bit product with no truncation. ovf compares the full 16-bit magnitude against DISP_MAX.

Optional Feature:
- Macro SIGNED_MUL_EN.
- Defined:
  - op_a/op_b are two's complement.
  - The controller drives magnitudes onto mul_a/mul_b; -128 maps to 8'h80 unsigned.
  - It stores the sign XOR and negates the captured mul_p when the signs differ.
  - result is 16-bit two's complement; ovf compares |result| against DISP_MAX.
  - Zero shortcut unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Package mul_seq_pkg holds:
  - state enum {IDLE, SETTLE, DONE}
  - OP_W=8, RES_W=16, CNT_W=4
  - default DISP_MAX constant
- One sub-module, mul_sign_fix: combinational operand magnitude conversion and product negation. It is instantiated only under SIGNED_MUL_EN.

Test Plan:
- Reset then op_a=12, op_b=34, SETTLE_CYCLES=2:
  - accept at T, res_valid at T+3, result=408, ovf=0.
  - req_ready low T+1..T+3.
- op_a=255, op_b=255:
  - result=65025, ovf=1.
  - Hold res_ready=0 for 5 cycles: result, res_valid and ovf stay stable.
- op_a=0, op_b=200: res_valid one cycle after accept, result=0, ovf=0, no SETTLE visit.
- rst asserted in SETTLE after accepting 100x100: next cycle all outputs at reset values. A new op 3x3 then yields 9.
- Back-to-back requests with req_valid held high: second pair is accepted only in the cycle after the res_ready handshake. Its mul_a/mul_b change only at that accept.
- With SIGNED_MUL_EN:
  - op_a=-5, op_b=7 gives result=16'hFFDD (-35).
  - -128 x -128 gives 16384, ovf=1.
